// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants, controller state encoding and the access-start decode
// used by the MEM-stage data-memory access controller.
package mem_access_ctrl_pkg;

    localparam int MAC_ADDR_W  = 22;
    localparam int MAC_DATA_W  = 32;
    localparam int MAC_TIMEOUT = 255;
    localparam int MAC_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_DRAIN = 2'b11
    } mac_state_t;

    // A flushed or halted instruction never starts a memory transaction.
    function automatic logic mem_access_start(
        input logic rd,
        input logic wr,
        input logic flush,
        input logic hlt
    );
        return (rd | wr) & ~flush & ~hlt;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the access controller (master) and data memory (slave).
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = MAC_ADDR_W,
    parameter int DATA_W = MAC_DATA_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );

endinterface

// File: rtl/mem_access_ctrl_access_timeout_ctr.sv
// Wait counter for an outstanding access: cleared at issue, advanced on each
// un-acknowledged cycle, flags the last cycle allowed before abandoning.
module access_timeout_ctr
    import mem_access_ctrl_pkg::*;
#(
    parameter int               CNT_W = MAC_CNT_W,
    parameter logic [CNT_W-1:0] LIMIT = CNT_W'(MAC_TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // Counter value n means n+1 BUSY cycles have elapsed, so LIMIT-1 is the last one.
    localparam logic [CNT_W-1:0] LAST = LIMIT - CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues load/store requests, stalls the
// pipeline while an access is outstanding and selects the value MEM/WB captures.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = MAC_ADDR_W,
    parameter int DATA_W  = MAC_DATA_W,
    parameter int TIMEOUT = MAC_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_mem_read,
    input  logic              MEM_mem_write,
    input  logic [DATA_W-1:0] MEM_ALU_result,
    input  logic [DATA_W-1:0] MEM_store_data,
    input  logic              flush,
    input  logic              hlt,
    input  logic              ext_stall,
    mem_access_ctrl_if.master dmem,
    output logic [DATA_W-1:0] MEM_mem_result,
    output logic              mem_stall,
    output logic              dmem_err
);

    mac_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              kill_q, kill_d;
    logic              err_q, err_d;

    logic              access;
    logic              killed;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_expire;

    access_timeout_ctr #(
        .CNT_W (MAC_CNT_W),
        .LIMIT (MAC_CNT_W'(TIMEOUT))
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expire (cnt_expire)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        we_d           = we_q;
        kill_d         = kill_q;
        err_d          = err_q;
        mem_stall      = 1'b0;
        MEM_mem_result = MEM_ALU_result;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        access         = mem_access_start(MEM_mem_read, MEM_mem_write, flush, hlt);
        // A flush arriving in the completing cycle still kills the instruction.
        killed         = kill_q | flush;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    mem_stall = 1'b1;
                    addr_d    = MEM_ALU_result[ADDR_W-1:0];
                    wdata_d   = MEM_store_data;
                    we_d      = MEM_mem_write;
                    kill_d    = 1'b0;
                    cnt_clr   = 1'b1;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                mem_stall = 1'b1;
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (dmem.ack) begin
                    if (!we_q) begin
                        rdata_d = dmem.rdata;
                    end
                    state_d = killed ? ST_DRAIN : ST_DONE;
                end else if (cnt_expire) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = killed ? ST_DRAIN : ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_DONE: begin
                MEM_mem_result = we_q ? MEM_ALU_result : rdata_q;
                // Hold the finished result until the rest of the pipeline can move.
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (!(ext_stall | hlt)) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                MEM_mem_result = '0;
                state_d        = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            kill_q  <= kill_d;
            err_q   <= err_d;
        end
    end

    // Request is a pure decode of the state flop so reset removes it without a clock.
    assign dmem.req   = (state_q == ST_BUSY);
    assign dmem.we    = dmem.req & we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: each scenario is described by its access
// timing, and expected per-cycle outputs are derived from that description.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd, wr, flush, hlt, ext_stall;
    logic [DW-1:0] alu, sd, res;
    logic          stall, err;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dmem_if ();

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_mem_read   (rd),
        .MEM_mem_write  (wr),
        .MEM_ALU_result (alu),
        .MEM_store_data (sd),
        .flush          (flush),
        .hlt            (hlt),
        .ext_stall      (ext_stall),
        .dmem           (dmem_if),
        .MEM_mem_result (res),
        .mem_stall      (stall),
        .dmem_err       (err)
    );

    typedef struct {
        bit          rd, wr, fl0, hl0, stray, hold_hlt;
        logic [31:0] alu, sd, rdata;
        int          ack_at, flush_at, hold;
    } scen_t;

    int n_vec, n_err;
    int stall_cnt, req_cnt, req_rise, post_cnt;
    logic [31:0] last_res;
    logic [AW-1:0] last_addr;
    logic prev_req;

    scen_t cur;
    bit    acc, drained, err_sticky, chk_en;
    int    busy_len;

    logic          exp_stall, exp_req, exp_we, exp_err, exp_res_vld;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata, exp_res;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic scen_t mk(bit r, bit w, logic [31:0] a, logic [31:0] s, logic [31:0] rdat,
                                 int ack_at, int flush_at = 0, int hold = 0, bit hold_hlt = 0,
                                 bit fl0 = 0, bit hl0 = 0, bit stray = 0);
        scen_t t;
        t.rd = r; t.wr = w; t.alu = a; t.sd = s; t.rdata = rdat;
        t.ack_at = ack_at; t.flush_at = flush_at; t.hold = hold; t.hold_hlt = hold_hlt;
        t.fl0 = fl0; t.hl0 = hl0; t.stray = stray;
        return t;
    endfunction

    // Cycle 0 is the issue cycle, cycles 1..busy_len carry the request, the rest are result cycles.
    task automatic apply_cycle(input int i);
        bit idle, busy, post;
        int p;
        idle = (i == 0);
        busy = acc && (i >= 1) && (i <= busy_len);
        post = acc && (i > busy_len);
        p    = i - busy_len - 1;
        rd = cur.rd; wr = cur.wr; alu = cur.alu; sd = cur.sd;
        flush     = (idle && cur.fl0) || (busy && i == cur.flush_at);
        hlt       = (idle && cur.hl0) || (post && cur.hold_hlt && p < cur.hold);
        ext_stall = post && !cur.hold_hlt && p < cur.hold;
        dmem_if.ack   = busy ? (i == cur.ack_at) : cur.stray;
        dmem_if.rdata = busy ? cur.rdata : ~cur.rdata;

        exp_stall   = acc && !post;
        exp_req     = busy;
        exp_we      = busy && cur.wr;
        exp_addr    = cur.alu[AW-1:0];
        exp_wdata   = cur.sd;
        exp_res_vld = !acc || post;
        if (!acc)                exp_res = cur.alu;
        else if (drained)        exp_res = 32'h0;
        else if (cur.wr)         exp_res = cur.alu;
        else if (cur.ack_at != 0) exp_res = cur.rdata;
        else                     exp_res = 32'h0;
        exp_err = err_sticky || (acc && cur.ack_at == 0 && post);
    endtask

    task automatic run_scen(input scen_t s);
        int total;
        cur      = s;
        acc      = (s.rd || s.wr) && !s.fl0 && !s.hl0;
        busy_len = (s.ack_at != 0) ? s.ack_at : TO;
        drained  = (s.flush_at != 0);
        total    = !acc ? 1 : busy_len + 2 + (drained ? 0 : s.hold);
        stall_cnt = 0; req_cnt = 0; req_rise = 0; post_cnt = 0;
        for (int i = 0; i < total; i++) begin
            apply_cycle(i);
            chk_en = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
        if (acc && s.ack_at == 0) err_sticky = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("mem_stall", 32'(stall), 32'(exp_stall));
                chk("dmem_req", 32'(dmem_if.req), 32'(exp_req));
                chk("dmem_we", 32'(dmem_if.we), 32'(exp_we));
                chk("dmem_err", 32'(err), 32'(exp_err));
                if (exp_req) begin
                    chk("dmem_addr", 32'(dmem_if.addr), 32'(exp_addr));
                    chk("dmem_wdata", dmem_if.wdata, exp_wdata);
                end
                if (exp_res_vld) begin
                    chk("mem_result", res, exp_res);
                    last_res = res;
                end
                if (stall) stall_cnt++;
                else       post_cnt++;
                if (dmem_if.req) begin
                    req_cnt++;
                    last_addr = dmem_if.addr;
                    if (!prev_req) req_rise++;
                end
                prev_req = dmem_if.req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0; n_err = 0; err_sticky = 1'b0; chk_en = 1'b0; prev_req = 1'b0;
        last_res = '0; last_addr = '0;
        rst = 1'b1; rd = 0; wr = 0; flush = 0; hlt = 0; ext_stall = 0;
        alu = '0; sd = '0; dmem_if.ack = 1'b0; dmem_if.rdata = '0;
        #1;
        chk("rst_req", 32'(dmem_if.req), 32'h0);
        chk("rst_we", 32'(dmem_if.we), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_addr", 32'(dmem_if.addr), 32'h0);
        chk("rst_wdata", dmem_if.wdata, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        run_scen(mk(0, 0, 32'h1234_5678, 32'h0, 32'h0, 0));
        chk("t1_result", last_res, 32'h1234_5678);
        chk("t1_stalls", 32'(stall_cnt), 32'd0);
        chk("t1_reqs", 32'(req_cnt), 32'd0);

        run_scen(mk(1, 0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1));
        chk("t2_stalls", 32'(stall_cnt), 32'd2);
        chk("t2_reqs", 32'(req_cnt), 32'd1);
        chk("t2_addr", 32'(last_addr), 32'h40);
        chk("t2_result", last_res, 32'hDEAD_BEEF);

        run_scen(mk(0, 1, 32'h003F_FFFC, 32'hA5A5_A5A5, 32'h0, 6));
        chk("t3_stalls", 32'(stall_cnt), 32'd7);
        chk("t3_reqs", 32'(req_cnt), 32'd6);
        chk("t3_addr", 32'(last_addr), 32'h3F_FFFC);
        chk("t3_result", last_res, 32'h003F_FFFC);

        run_scen(mk(0, 0, 32'hCAFE_0001, 32'h0, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 1));
        chk("stray_result", last_res, 32'hCAFE_0001);
        chk("stray_reqs", 32'(req_cnt), 32'd0);

        run_scen(mk(1, 0, 32'h0000_0100, 32'h0, 32'h0, 1, 0, 0, 0, 1, 0, 0));
        chk("idle_flush_stalls", 32'(stall_cnt), 32'd0);
        run_scen(mk(0, 1, 32'h0000_0200, 32'h1, 32'h0, 1, 0, 0, 0, 0, 1, 0));
        chk("idle_hlt_stalls", 32'(stall_cnt), 32'd0);

        run_scen(mk(1, 1, 32'h0000_1000, 32'h1111_2222, 32'h9999_9999, 2));
        chk("rdwr_result", last_res, 32'h0000_1000);

        run_scen(mk(1, 0, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 3, 2));
        chk("t5_result", last_res, 32'h0);
        chk("t5_reqs", 32'(req_cnt), 32'd3);
        chk("t5_stalls", 32'(stall_cnt), 32'd4);

        run_scen(mk(1, 0, 32'hFFC0_0080, 32'h0, 32'h0BAD_F00D, 1));
        chk("after_drain_addr", 32'(last_addr), 32'h80);
        chk("after_drain_result", last_res, 32'h0BAD_F00D);

        run_scen(mk(1, 0, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 1, 0, 3, 0, 0, 0, 1));
        chk("t6_done_cycles", 32'(post_cnt), 32'd4);
        chk("t6_transactions", 32'(req_rise), 32'd1);
        chk("t6_result", last_res, 32'h1357_9BDF);

        run_scen(mk(1, 0, 32'h0000_0500, 32'h0, 32'h2468_ACE0, 2, 0, 2, 1));
        chk("hlt_done_cycles", 32'(post_cnt), 32'd3);

        run_scen(mk(1, 0, 32'h0000_0600, 32'h0, 32'hFFFF_0000, 0));
        chk("t4_reqs", 32'(req_cnt), 32'd255);
        chk("t4_result", last_res, 32'h0);
        chk("t4_err", 32'(err), 32'h1);

        run_scen(mk(0, 1, 32'h0000_0700, 32'hDEAD_0001, 32'h0, 1));
        chk("err_sticky", 32'(err), 32'h1);

        rd = 1'b1; wr = 1'b0; alu = 32'h0000_0800; flush = 0; hlt = 0; ext_stall = 0;
        dmem_if.ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_pre_req", 32'(dmem_if.req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_req", 32'(dmem_if.req), 32'h0);
        chk("rst_mid_err", 32'(err), 32'h0);
        chk("rst_mid_addr", 32'(dmem_if.addr), 32'h0);
        rd = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        err_sticky = 1'b0;
        prev_req = 1'b0;

        run_scen(mk(0, 0, 32'h0BAD_CAFE, 32'h0, 32'h0, 0));
        chk("post_rst_result", last_res, 32'h0BAD_CAFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Runs a request/acknowledge handshake with data memory for loads and stores and stalls the pipeline while an access is outstanding.
- Presents the value that MEM/WB captures as its memory/ALU result: load data for loads, the ALU result otherwise.

Parameters:
- ADDR_W, 22, data-memory address width (matches PC/address width)
- DATA_W, 32, data word width
- TIMEOUT, 255, BUSY cycles without ack before the access is abandoned (counter width 8)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MEM_mem_read  in  1  current MEM instruction is a load
- MEM_mem_write  in  1  current MEM instruction is a store
- MEM_ALU_result  in  DATA_W  effective address (low ADDR_W bits) or non-memory result
- MEM_store_data  in  DATA_W  store data
- flush  in  1  kill the current MEM instruction
- hlt  in  1  processor halted
- ext_stall  in  1  stall from other hazard sources holding the MEM instruction in place
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = write, 0 = read; valid with dmem_req
- dmem_addr  out  ADDR_W  latched address
- dmem_wdata  out  DATA_W  latched store data
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- MEM_mem_result  out  DATA_W  value for MEM/WB to capture
- mem_stall  out  1  stall request to all upstream pipeline registers and MEM/WB
- dmem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, active-high):
  - state = IDLE; dmem_req, dmem_we, mem_stall, dmem_err = 0
  - dmem_addr, dmem_wdata, rdata_q, timeout counter = 0
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - access = (MEM_mem_read | MEM_mem_write) & !flush & !hlt.
  - If access: mem_stall = 1 (combinational, same cycle). Latch addr = MEM_ALU_result[ADDR_W-1:0], wdata = MEM_store_data, we = MEM_mem_write. Clear counter. Next state BUSY.
  - If not access: mem_stall = 0 and MEM_mem_result = MEM_ALU_result (pass-through, zero latency).
  - mem_read and mem_write both high: treated as a store.
- BUSY:
  - dmem_req = 1, mem_stall = 1. Latched addr, wdata and we stay stable.
  - On dmem_ack: capture rdata_q = dmem_rdata (loads only); next state DONE.
  - No ack: counter increments. When counter reaches TIMEOUT, set dmem_err, rdata_q = 0, drop req, next state DONE.
  - flush in BUSY: the transaction cannot be aborted. Set kill flag; on ack or timeout, next state DRAIN instead of DONE.
- DONE:
  - mem_stall = 0. MEM_mem_result = rdata_q for loads, MEM_ALU_result for stores.
  - If ext_stall = 1 or hlt = 1: remain in DONE, no re-issue.
  - Otherwise next state IDLE; the pipeline advances on this edge.
  - flush in DONE: next state IDLE.
- DRAIN: mem_stall = 0, result = 0, next state IDLE. The flushed instruction leaves without effect on WB.
- Minimum load/store latency with ack in the first BUSY cycle: 3 cycles (IDLE, BUSY, DONE), i.e. 2 stall cycles.
- dmem_ack outside BUSY is ignored. dmem_err clears only on reset.
- Reset mid-BUSY: dmem_req drops immediately (async); memory side must tolerate an abandoned request.
- hlt during BUSY: the access completes normally; the controller then holds in DONE until hlt is released.

Decomposition:
- Shared package (cpu_pkg): ADDR_W/DATA_W constants; state enum {IDLE, BUSY, DONE, DRAIN} as a 2-bit localparam encoding.
- One sub-module: access_timeout_ctr (8-bit counter with clear/enable/expire). Everything else in one always_ff/always_comb pair.

Test Plan:
- Non-memory instruction, MEM_ALU_result = 0x1234_5678 -> MEM_mem_result = 0x1234_5678 same cycle; mem_stall = 0; dmem_req never asserted.
- Load addr 0x00_0040, ack 1 cycle after req with rdata 0xDEAD_BEEF -> mem_stall high exactly 2 cycles; dmem_req 1 cycle, dmem_we = 0, dmem_addr = 0x40; DONE shows MEM_mem_result = 0xDEAD_BEEF.
- Store addr 0x3F_FFFC, data 0xA5A5_A5A5, ack delayed 5 cycles -> req and we held high 6 cycles with addr/data stable; mem_stall high 7 cycles; MEM_mem_result = ALU result in DONE.
- Load, never acked -> after 255 BUSY cycles req drops, dmem_err = 1 (sticky), MEM_mem_result = 0 in DONE.
- Load with flush in the 2nd BUSY cycle, ack in the 3rd -> DRAIN follows, result 0, no re-issue; next instruction accepted the following cycle.
- Load completes with ext_stall high for 3 cycles in DONE -> remains in DONE 4 cycles, exactly one dmem_req transaction; assert rst during a later BUSY -> dmem_req falls with no clock edge, state IDLE.
